// File: rtl/bitop_cmd_unit.sv
// Purpose : valid/ready command front-end for the 16-bit bitwise unit (AND/OR/invert-a).
//           Registers one command, holds it on alu_a/alu_b/alu_op for SETTLE_CYCLES,
//           captures alu_out and returns it with zero/error flags.
// Latency : legal op -> rsp_valid sampled high SETTLE_CYCLES+1 edges after acceptance;
//           illegal op (3) -> 1 edge after acceptance.
// Backpr. : single command in flight; cmd_ready only in IDLE, response held
//           stable until rsp_ready is sampled high.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   cmd_valid/cmd_ready          command handshake; cmd_a, cmd_b, cmd_op payload
//   alu_a/alu_b/alu_op           registered operands driven to the bitwise unit
//   alu_out                      combinational result from the bitwise unit
//   rsp_valid/rsp_ready          response handshake; rsp_data, rsp_zero, rsp_err payload
//   cmd_count                    responses consumed (wraps at 16 bits)

module bitop_cmd_unit #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [1:0]  cmd_op,

  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [1:0]  alu_op,
  input  logic [15:0] alu_out,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_err,

  output logic [15:0] cmd_count
);

  // Out-of-range settings are clamped into the 4-bit counter's 1..15 range.
  localparam int unsigned SETTLE_EFF =
      (SETTLE_CYCLES < 1)  ? 1  :
      (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_EFF - 1);
  localparam logic [1:0] OP_ILLEGAL  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q,     state_d;
  logic [3:0]  settle_q,    settle_d;
  logic [15:0] opa_q,       opa_d;
  logic [15:0] opb_q,       opb_d;
  logic [1:0]  opc_q,       opc_d;
  logic [15:0] rsp_data_q,  rsp_data_d;
  logic        rsp_zero_q,  rsp_zero_d;
  logic        rsp_err_q,   rsp_err_d;
  logic [15:0] cmd_count_q, cmd_count_d;

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      settle_q    <= 4'd0;
      opa_q       <= 16'h0000;
      opb_q       <= 16'h0000;
      opc_q       <= 2'd0;
      rsp_data_q  <= 16'h0000;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      cmd_count_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      opc_q       <= opc_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
      cmd_count_q <= cmd_count_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state and handshake outputs
  // ------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    opc_d       = opc_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;
    cmd_count_d = cmd_count_q;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          // Operands load even for the illegal opcode so the datapath
          // inputs always show the last accepted command.
          opa_d = cmd_a;
          opb_d = cmd_b;
          opc_d = cmd_op;
          if (cmd_op == OP_ILLEGAL) begin
            // No point waiting on the datapath; answer with an error.
            rsp_data_d = 16'h0000;
            rsp_zero_d = 1'b0;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
          end else begin
            settle_d = SETTLE_INIT;
            state_d  = EXEC;
          end
        end
      end

      EXEC: begin
        if (settle_q == 4'd0) begin
          rsp_data_d = alu_out;
          rsp_zero_d = (alu_out == 16'h0000);
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          cmd_count_d = cmd_count_q + 16'd1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Output wiring
  // ------------------------------------------------------------------
  assign alu_a     = opa_q;
  assign alu_b     = opb_q;
  assign alu_op    = opc_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign cmd_count = cmd_count_q;

endmodule

// File: tb/tb_bitop_cmd_unit.sv
module tb_bitop_cmd_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cmd_a, cmd_b;
  logic [1:0]  cmd_op;

  // Instance with SETTLE_CYCLES=1
  logic        cv1, cr1, ra1, rv1, rz1, re1;
  logic [15:0] aa1, ab1, aout1, rd1, cc1;
  logic [1:0]  ao1;
  // Instance with SETTLE_CYCLES=4
  logic        cv4, cr4, ra4, rv4, rz4, re4;
  logic [15:0] aa4, ab4, aout4, rd4, cc4;
  logic [1:0]  ao4;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the downstream bitwise unit.
  function automatic logic [15:0] bitop(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return ~a;
      default: return 16'h0000;
    endcase
  endfunction

  assign aout1 = bitop(aa1, ab1, ao1);
  assign aout4 = bitop(aa4, ab4, ao4);

  bitop_cmd_unit #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cv1), .cmd_ready(cr1), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(aa1), .alu_b(ab1), .alu_op(ao1), .alu_out(aout1),
    .rsp_valid(rv1), .rsp_ready(ra1), .rsp_data(rd1), .rsp_zero(rz1), .rsp_err(re1),
    .cmd_count(cc1)
  );

  bitop_cmd_unit #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cv4), .cmd_ready(cr4), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(aa4), .alu_b(ab4), .alu_op(ao4), .alu_out(aout4),
    .rsp_valid(rv4), .rsp_ready(ra4), .rsp_data(rd4), .rsp_zero(rz4), .rsp_err(re4),
    .cmd_count(cc4)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present a command at a negedge; it is accepted on the following posedge.
  task automatic issue(input int which, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] op);
    @(negedge clk);
    cmd_a  = a;
    cmd_b  = b;
    cmd_op = op;
    if (which == 1) begin
      chk("cmd_ready_idle_1", {15'd0, cr1}, 16'd1);
      cv1 = 1'b1;
    end else begin
      chk("cmd_ready_idle_4", {15'd0, cr4}, 16'd1);
      cv4 = 1'b1;
    end
    @(posedge clk);
    #1;
    cv1 = 1'b0;
    cv4 = 1'b0;
  endtask

  // Number of posedges after acceptance at which rsp_valid is first sampled high.
  task automatic wait_rsp(input int which, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 50) begin
      @(negedge clk);
      lat++;
      seen = (which == 1) ? rv1 : rv4;
    end
  endtask

  initial begin
    int lat;
    int hi_cnt;

    rst_n = 1'b0;
    cv1 = 1'b0; ra1 = 1'b0; cv4 = 1'b0; ra4 = 1'b0;
    cmd_a = 16'h0; cmd_b = 16'h0; cmd_op = 2'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {15'd0, cr1}, 16'd1);
    chk("rst_rsp_valid", {15'd0, rv1}, 16'd0);
    chk("rst_rsp_data",  rd1, 16'h0000);
    chk("rst_alu_a",     aa1, 16'h0000);
    chk("rst_cmd_count", cc1, 16'h0000);
    rst_n = 1'b1;

    // AND, rsp_ready held high
    ra1 = 1'b1;
    issue(1, 16'hF0F0, 16'h3C3C, 2'd0);
    wait_rsp(1, lat);
    chk("and_latency", 16'(lat), 16'd2);
    chk("and_data",    rd1, 16'h3030);
    chk("and_zero",    {15'd0, rz1}, 16'd0);
    chk("and_err",     {15'd0, re1}, 16'd0);
    @(posedge clk); #1;
    chk("and_count",   cc1, 16'd1);
    chk("and_rsp_gone", {15'd0, rv1}, 16'd0);

    // OR with 5 cycles of backpressure
    ra1 = 1'b0;
    issue(1, 16'h00FF, 16'hFF00, 2'd1);
    wait_rsp(1, lat);
    chk("or_latency", 16'(lat), 16'd2);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("or_hold_valid", {15'd0, rv1}, 16'd1);
      chk("or_hold_data",  rd1, 16'hFFFF);
      chk("or_hold_ready", {15'd0, cr1}, 16'd0);
      chk("or_hold_count", cc1, 16'd1);
    end
    @(negedge clk);
    ra1 = 1'b1;
    @(posedge clk); #1;
    chk("or_count",     cc1, 16'd2);
    chk("or_rsp_gone",  {15'd0, rv1}, 16'd0);
    chk("or_ready_back", {15'd0, cr1}, 16'd1);

    // Invert-a giving zero; a second command offered during EXEC/RESP
    ra1 = 1'b0;
    issue(1, 16'hFFFF, 16'h1234, 2'd2);
    @(negedge clk);
    chk("inv_exec_valid", {15'd0, rv1}, 16'd0);
    chk("inv_exec_ready", {15'd0, cr1}, 16'd0);
    cmd_a  = 16'h5555;
    cmd_b  = 16'h0F0F;
    cmd_op = 2'd0;
    cv1    = 1'b1;
    @(negedge clk);
    chk("inv_valid", {15'd0, rv1}, 16'd1);
    chk("inv_data",  rd1, 16'h0000);
    chk("inv_zero",  {15'd0, rz1}, 16'd1);
    chk("inv_err",   {15'd0, re1}, 16'd0);
    chk("inv_alu_a_kept", aa1, 16'hFFFF);
    ra1 = 1'b1;
    @(posedge clk); #1;
    cv1 = 1'b0;
    chk("inv_count", cc1, 16'd3);
    chk("inv_alu_op_kept", {14'd0, ao1}, 16'd2);
    @(negedge clk);
    chk("inv_no_second", {15'd0, rv1}, 16'd0);

    // Illegal opcode
    issue(1, 16'h1111, 16'h2222, 2'd3);
    wait_rsp(1, lat);
    chk("ill_latency", 16'(lat), 16'd1);
    chk("ill_data",    rd1, 16'h0000);
    chk("ill_err",     {15'd0, re1}, 16'd1);
    chk("ill_zero",    {15'd0, rz1}, 16'd0);
    chk("ill_alu_a",   aa1, 16'h1111);
    @(posedge clk); #1;
    chk("ill_count",   cc1, 16'd4);
    ra1 = 1'b0;

    // SETTLE_CYCLES=4: AND giving zero, operands stable during EXEC
    issue(4, 16'hAAAA, 16'h5555, 2'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s4_exec_valid", {15'd0, rv4}, 16'd0);
      chk("s4_alu_a", aa4, 16'hAAAA);
      chk("s4_alu_b", ab4, 16'h5555);
      chk("s4_alu_op", {14'd0, ao4}, 16'd0);
    end
    @(negedge clk);
    chk("s4_valid", {15'd0, rv4}, 16'd1);
    chk("s4_data",  rd4, 16'h0000);
    chk("s4_zero",  {15'd0, rz4}, 16'd1);
    ra4 = 1'b1;
    @(posedge clk); #1;
    chk("s4_count", cc4, 16'd1);
    ra4 = 1'b0;

    // Reset asserted mid-EXEC
    ra4 = 1'b1;
    issue(4, 16'hFFFF, 16'h00FF, 2'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {15'd0, rv4}, 16'd0);
    chk("mrst_alu_a", aa4, 16'h0000);
    chk("mrst_alu_b", ab4, 16'h0000);
    chk("mrst_data",  rd4, 16'h0000);
    chk("mrst_zero",  {15'd0, rz4}, 16'd0);
    chk("mrst_count", cc4, 16'h0000);
    chk("mrst_ready", {15'd0, cr4}, 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rv4) hi_cnt++;
    end
    chk("mrst_no_rsp", 16'(hi_cnt), 16'd0);
    chk("mrst_count_after", cc4, 16'h0000);
    ra4 = 1'b0;

    // Count wrap: preload near the top, then two handshakes
    @(negedge clk);
    force dut1.cmd_count_q = 16'hFFFE;
    #1;
    release dut1.cmd_count_q;
    chk("wrap_preload", cc1, 16'hFFFE);
    ra1 = 1'b1;
    issue(1, 16'h0001, 16'h0000, 2'd3);
    wait_rsp(1, lat);
    @(posedge clk); #1;
    chk("wrap_ffff", cc1, 16'hFFFF);
    issue(1, 16'h0002, 16'h0000, 2'd3);
    wait_rsp(1, lat);
    @(posedge clk); #1;
    chk("wrap_zero", cc1, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bitop_cmd_unit.md
# bitop_cmd_unit

Command front-end for the 16-bit bitwise operation unit (AND / OR / invert-a). Accepts operand/opcode commands over a valid/ready handshake, registers and holds them on the datapath inputs for a programmable settle window, captures the combinational result, and returns it with zero and error flags over a second valid/ready handshake. It sits directly upstream of the bitwise unit, driving its `a`/`b`/`op` inputs, and consumes its `out`.

## Interface
- SETTLE_CYCLES, 1, cycles operands are held on the datapath before `alu_out` is captured; legal range 1..15.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  unit can accept a command.
- cmd_a  in  16  operand a.
- cmd_b  in  16  operand b.
- cmd_op  in  2  0=AND, 1=OR, 2=invert a, 3=illegal.
- alu_a  out  16  registered operand a to the bitwise unit.
- alu_b  out  16  registered operand b to the bitwise unit.
- alu_op  out  2  registered opcode to the bitwise unit.
- alu_out  in  16  combinational result from the bitwise unit.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  16  captured result.
- rsp_zero  out  1  rsp_data == 16'h0000 (forced 0 when rsp_err).
- rsp_err  out  1  command carried op=3.
- cmd_count  out  16  number of responses consumed; wraps 16'hFFFF -> 16'h0000.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready: load cmd_a/cmd_b/cmd_op into operand registers. op 0..2 -> EXEC, settle counter loaded with SETTLE_CYCLES-1. op=3 -> RESP directly, rsp_data=0, rsp_err=1, rsp_zero=0; operand registers still load.
- EXEC: cmd_ready=0; alu_a/alu_b/alu_op stable. Counter decrements each cycle; on the cycle counter==0, alu_out captured into rsp_data, rsp_zero computed from captured value, rsp_err=0, state -> RESP.
- RESP: rsp_valid=1, rsp_data/rsp_zero/rsp_err stable until handshake. On rsp_valid&rsp_ready: cmd_count+=1 (wrapping), state -> IDLE. No new command is accepted in the same cycle as response handshake (cmd_ready is 0 in RESP).
- alu_* outputs always reflect the operand registers; they change only on command acceptance.
- No buffering: at most one command in flight.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, cmd_ready=1 after release, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_err=0, alu_a=0, alu_b=0, alu_op=0, cmd_count=0, settle counter=0.
- Reset asserted mid-EXEC or mid-RESP: in-flight command discarded, no response issued, cmd_count not incremented.
- Legal-op latency: command accepted at edge N; EXEC occupies SETTLE_CYCLES cycles; rsp_valid high from edge N+SETTLE_CYCLES+1. SETTLE_CYCLES=1 -> rsp_valid two edges after acceptance.
- Illegal-op latency: rsp_valid high from edge N+1.
- Back-to-back throughput: minimum SETTLE_CYCLES+2 cycles per command with rsp_ready held high (acceptance, EXEC, RESP handshake, return to IDLE).
- cmd_valid/cmd_a/cmd_b/cmd_op ignored outside IDLE; rsp_ready ignored outside RESP.
- rsp_valid, once high, stays high with stable payload until rsp_ready sampled high.

## Test plan
- Reset then AND: a=16'hF0F0, b=16'h3C3C, op=0, rsp_ready=1 -> rsp_valid 2 edges after acceptance, rsp_data=16'h3030, rsp_zero=0, rsp_err=0, cmd_count=1.
- OR with backpressure: a=16'h00FF, b=16'hFF00, op=1, rsp_ready low 5 cycles -> rsp_valid held, rsp_data=16'hFFFF stable, cmd_ready=0 throughout; count increments only on the handshake cycle.
- Invert and zero flag: a=16'hFFFF, b=16'h1234, op=2 -> rsp_data=16'h0000, rsp_zero=1; second command ignored while in EXEC/RESP.
- Illegal op: op=3, a=16'h1111 -> rsp_valid 1 edge after acceptance, rsp_data=0, rsp_err=1, rsp_zero=0; alu_a=16'h1111.
- SETTLE_CYCLES=4: AND 16'hAAAA & 16'h5555 -> rsp_valid 5 edges after acceptance, rsp_data=0, rsp_zero=1; alu_* stable all 4 EXEC cycles.
- Reset mid-EXEC, then count wrap: assert rst_n low during EXEC -> all outputs reset, no response; separately force 65536 commands -> cmd_count returns to 16'h0000.
